// File: rtl/line3_feeder.sv
// Three-line raster buffer: turns one pixel stream into vertically aligned
// (r-2, r-1, r) column triples for a 3x3 window stage.
module line3_feeder #(
    parameter int LINE_W = 640,
    parameter int DW     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] odata1,
    output logic [DW-1:0] odata2,
    output logic [DW-1:0] odata3,
    output logic          out_eol,
    output logic [1:0]    dbg_state_o
);

    localparam int CW = $clog2(LINE_W);
    localparam logic [CW-1:0] LAST_COL = CW'(LINE_W - 1);

    // Handshake: in_valid qualifies in_data/in_sof for one cycle and there is no
    // backpressure; out_valid qualifies odata1..3/out_eol for exactly one cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL0  = 2'd1,
        FILL1  = 2'd2,
        STREAM = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic            out_valid_q;
    logic            out_eol_q;
    logic [DW-1:0]   odata1_q, odata2_q, odata3_q;

    logic [DW-1:0]   line_a_q [LINE_W];
    logic [DW-1:0]   line_b_q [LINE_W];

    logic            accept;
    logic [CW-1:0]   wcol;
    logic            at_wrap;
    logic            stream_beat;

    // An sof beat is always column 0, whatever the counter says.
    assign accept      = in_valid & (in_sof | (state_q != IDLE));
    assign wcol        = in_sof ? '0 : col_q;
    assign at_wrap     = (wcol == LAST_COL);
    assign stream_beat = in_valid & ~in_sof & (state_q == STREAM);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        if (in_valid) begin
            if (in_sof) begin
                state_d = FILL0;
                col_d   = CW'(1);
            end else if (state_q != IDLE) begin
                col_d = at_wrap ? '0 : col_q + CW'(1);
                if (at_wrap) begin
                    case (state_q)
                        FILL0:   state_d = FILL1;
                        FILL1:   state_d = STREAM;
                        default: state_d = state_q;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            out_eol_q   <= 1'b0;
            odata1_q    <= '0;
            odata2_q    <= '0;
            odata3_q    <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            out_valid_q <= stream_beat;
            out_eol_q   <= stream_beat & (col_q == LAST_COL);
            if (accept) begin
                odata1_q <= line_a_q[wcol];
                odata2_q <= line_b_q[wcol];
                odata3_q <= in_data;
            end
        end
    end

    // Line memories are never cleared; the FILL0/FILL1 rows overwrite every
    // column before anything read from them can be flagged valid.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            line_a_q[wcol] <= line_b_q[wcol];
            line_b_q[wcol] <= in_data;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_eol     = out_eol_q;
    assign odata1      = odata1_q;
    assign odata2      = odata2_q;
    assign odata3      = odata3_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_line3_feeder.sv
// Bench for line3_feeder: a 4-pixel-wide instance for directed frames and a
// 4096-wide instance for a random frame, each with its own expected queue.
module tb_line3_feeder;

    localparam int DW = 8;
    localparam int W4 = 4;
    localparam int WB = 4096;

    logic clk = 1'b0;
    logic rst;

    logic          a_valid, a_sof;
    logic [DW-1:0] a_data;
    logic          a_out_valid, a_out_eol;
    logic [DW-1:0] a_odata1, a_odata2, a_odata3;
    logic [1:0]    a_state;

    logic          b_valid, b_sof;
    logic [DW-1:0] b_data;
    logic          b_out_valid, b_out_eol;
    logic [DW-1:0] b_odata1, b_odata2, b_odata3;
    logic [1:0]    b_state;

    int total = 0;
    int bad   = 0;

    logic [3*DW:0]   exp_a_q[$];
    logic [3*DW:0]   exp_b_q[$];
    logic [3*DW-1:0] last_trip;
    logic            last_out;
    logic [DW-1:0]   big_frame [0:4][0:WB-1];

    line3_feeder #(.LINE_W(W4), .DW(DW)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_sof(a_sof), .in_data(a_data),
        .out_valid(a_out_valid), .odata1(a_odata1), .odata2(a_odata2), .odata3(a_odata3),
        .out_eol(a_out_eol), .dbg_state_o(a_state)
    );

    line3_feeder #(.LINE_W(WB), .DW(DW)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_sof(b_sof), .in_data(b_data),
        .out_valid(b_out_valid), .odata1(b_odata1), .odata2(b_odata2), .odata3(b_odata3),
        .out_eol(b_out_eol), .dbg_state_o(b_state)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pix(input int base, input int r, input int c);
        return DW'(base + r * 16 + c);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitors: pop one expected {eol, top, mid, bot} per output beat.
    always @(negedge clk) begin
        if (a_out_valid === 1'b1) begin
            if (exp_a_q.size() == 0) begin
                check("w4_unexpected_out", 32'({a_out_eol, a_odata1, a_odata2, a_odata3}), 32'hFFFF_FFFF);
            end else begin
                check("w4_triple", 32'({a_out_eol, a_odata1, a_odata2, a_odata3}), 32'(exp_a_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (b_out_valid === 1'b1) begin
            if (exp_b_q.size() == 0) begin
                check("w4096_unexpected_out", 32'({b_out_eol, b_odata1, b_odata2, b_odata3}), 32'hFFFF_FFFF);
            end else begin
                check("w4096_triple", 32'({b_out_eol, b_odata1, b_odata2, b_odata3}), 32'(exp_b_q.pop_front()));
            end
        end
    end

    // One cycle on the narrow instance. live=0 means the DUT should be idle.
    task automatic beat4(input logic v, input logic sof, input int base, input int r,
                         input int c, input logic live);
        logic          exp_out;
        logic [DW-1:0] d;
        d = pix(base, r, c);
        exp_out = v && live && !sof && (r >= 2);
        if (exp_out)
            exp_a_q.push_back({(c == W4 - 1), pix(base, r - 2, c), pix(base, r - 1, c), d});
        a_valid = v;
        a_sof   = sof;
        a_data  = d;
        @(posedge clk);
        #1;
        check("w4_out_valid", 32'(a_out_valid), 32'(exp_out));
        if (!v && last_out)
            check("w4_hold", 32'({a_odata1, a_odata2, a_odata3}), 32'(last_trip));
        if (v && (live || sof)) begin
            last_out  = exp_out;
            last_trip = {pix(base, r - 2, c), pix(base, r - 1, c), d};
        end
        a_valid = 1'b0;
        a_sof   = 1'b0;
    endtask

    task automatic rows4(input int base, input int r0, input int r1, input logic sof_first,
                         input logic bubble);
        int k;
        k = 0;
        for (int r = r0; r <= r1; r++) begin
            for (int c = 0; c < W4; c++) begin
                beat4(1'b1, sof_first && (r == r0) && (c == 0), base, r, c, 1'b1);
                if (bubble && (k % 2 == 0)) begin
                    beat4(1'b0, 1'b0, base, r, c, 1'b1);
                    beat4(1'b0, 1'b0, base, r, c, 1'b1);
                end
                k++;
            end
        end
    endtask

    task automatic check_zero_a(input string name);
        check({name, "_valid"}, 32'(a_out_valid), 32'd0);
        check({name, "_eol"}, 32'(a_out_eol), 32'd0);
        check({name, "_odata"}, 32'({a_odata1, a_odata2, a_odata3}), 32'd0);
        check({name, "_state"}, 32'(a_state), 32'd0);
    endtask

    initial begin
        last_out  = 1'b0;
        last_trip = '0;
        a_valid = 1'b0; a_sof = 1'b0; a_data = '0;
        b_valid = 1'b0; b_sof = 1'b0; b_data = '0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero_a("reset");
        check("reset_b_state", 32'(b_state), 32'd0);
        check("reset_b_valid", 32'(b_out_valid), 32'd0);
        rst = 1'b0;

        // Valid pixels with no sof are all dropped.
        for (int k = 0; k < 20; k++) beat4(1'b1, 1'b0, 8'h55, 1, k % W4, 1'b0);
        check_zero_a("idle");

        // Continuous frame, then the same frame with bubbles, back to back.
        rows4(0, 0, 3, 1'b1, 1'b0);
        rows4(0, 0, 3, 1'b1, 1'b1);

        // sof in the middle of row 3.
        rows4(0, 0, 2, 1'b1, 1'b0);
        beat4(1'b1, 1'b0, 0, 3, 0, 1'b1);
        beat4(1'b1, 1'b0, 0, 3, 1, 1'b1);
        rows4(8'h80, 0, 3, 1'b1, 1'b0);

        // sof landing on the last column of a line.
        rows4(0, 0, 2, 1'b1, 1'b0);
        for (int c = 0; c < W4 - 1; c++) beat4(1'b1, 1'b0, 0, 3, c, 1'b1);
        beat4(1'b1, 1'b1, 8'h40, 0, 0, 1'b1);
        check("sof_wrap_state", 32'(a_state), 32'd1);
        for (int c = 1; c < W4; c++) beat4(1'b1, 1'b0, 8'h40, 0, c, 1'b1);
        rows4(8'h40, 1, 2, 1'b0, 1'b0);

        // Reset in the middle of streaming row 4.
        rows4(0, 0, 3, 1'b1, 1'b0);
        beat4(1'b1, 1'b0, 0, 4, 0, 1'b1);
        beat4(1'b1, 1'b0, 0, 4, 1, 1'b1);
        rst = 1'b1; a_valid = 1'b1; a_data = pix(0, 4, 2);
        @(posedge clk);
        #1;
        rst = 1'b0; a_valid = 1'b0;
        check_zero_a("midrst");
        last_out = 1'b0;
        for (int k = 0; k < 6; k++) beat4(1'b1, 1'b0, 0, 4, k % W4, 1'b0);
        rows4(8'h20, 0, 2, 1'b1, 1'b0);
        beat4(1'b0, 1'b0, 0, 0, 0, 1'b1);

        // Wide instance: five random rows against a frame-indexed model.
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < WB; c++) begin
                big_frame[r][c] = DW'($urandom_range(0, 255));
                if (r >= 2)
                    exp_b_q.push_back({(c == WB - 1), big_frame[r - 2][c], big_frame[r - 1][c],
                                       big_frame[r][c]});
                b_valid = 1'b1;
                b_sof   = (r == 0) && (c == 0);
                b_data  = big_frame[r][c];
                @(posedge clk);
                #1;
            end
        end
        b_valid = 1'b0;
        b_sof   = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        check("w4_queue_drained", 32'(exp_a_q.size()), 32'd0);
        check("w4096_queue_drained", 32'(exp_b_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
